shift_seq_ctrl: RTL

//  Command sequencer for the left/right shift register datapath.

---
 rtl/shift_seq_ctrl.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/shift_seq_ctrl.sv
// -----------------------------------------------------------------------------
// shift_seq_ctrl
//   Command sequencer for a left/right shift register datapath. A command
//   (direction, rotate/shift, fill bit, step count, operand) is accepted over a
//   valid/ready handshake, the register is stepped one bit per clock for the
//   requested count, and the result is offered over a second valid/ready
//   handshake. Only one command is in flight at a time.
//
// Parameters
//   WIDTH  operand/result width in bits
//   AMT_W  step-count field width; 2**AMT_W-1 must be >= WIDTH
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous, active-high reset
//   cmd_valid   command present
//   cmd_ready   block can accept a command (IDLE)
//   cmd_lr_bar  1 = shift toward MSB, 0 = shift toward LSB
//   cmd_rot     1 = rotate, 0 = logical shift with fill bit
//   cmd_fill    bit shifted in when cmd_rot = 0
//   cmd_amt     number of single-bit steps
//   cmd_data    operand loaded into the shift register
//   busy        high while stepping (SHIFT)
//   res_valid   result available (DONE)
//   res_ready   consumer accepts result
//   res_data    current shift register contents
// -----------------------------------------------------------------------------
module shift_seq_ctrl #(
    parameter int WIDTH = 4,
    parameter int AMT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_lr_bar,
    input  logic             cmd_rot,
    input  logic             cmd_fill,
    input  logic [AMT_W-1:0] cmd_amt,
    input  logic [WIDTH-1:0] cmd_data,
    output logic             busy,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    localparam logic [AMT_W-1:0] WIDTH_AMT = AMT_W'(WIDTH);
    localparam logic [AMT_W-1:0] ONE_AMT   = AMT_W'(1);
    localparam logic [AMT_W-1:0] ZERO_AMT  = AMT_W'(0);

    state_t             state_r;
    state_t             state_s;
    logic [WIDTH-1:0]   shift_r;
    logic [WIDTH-1:0]   step_s;
    logic [AMT_W-1:0]   cnt_r;
    logic [AMT_W-1:0]   load_cnt_s;
    logic               dir_r;
    logic               rot_r;
    logic               fill_r;
    logic               shift_in_s;
    logic               cmd_ready_r;
    logic               busy_r;
    logic               res_valid_r;

    // Step count for a new command: logical shifts saturate at WIDTH because
    // further steps only push more fill bits; rotates keep the full count.
    always_comb begin
        load_cnt_s = cmd_amt;
        if (!cmd_rot && (cmd_amt > WIDTH_AMT)) begin
            load_cnt_s = WIDTH_AMT;
        end else begin
            load_cnt_s = cmd_amt;
        end
    end

    // One-bit step of the latched operand in the latched direction.
    always_comb begin
        shift_in_s = fill_r;
        step_s     = shift_r;
        if (dir_r) begin
            shift_in_s = rot_r ? shift_r[WIDTH-1] : fill_r;
            step_s     = {shift_r[WIDTH-2:0], shift_in_s};
        end else begin
            shift_in_s = rot_r ? shift_r[0] : fill_r;
            step_s     = {shift_in_s, shift_r[WIDTH-1:1]};
        end
    end

    // Next-state logic for the IDLE -> SHIFT -> DONE -> IDLE sequence.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_s = (load_cnt_s != ZERO_AMT) ? ST_SHIFT : ST_DONE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (cnt_r == ONE_AMT) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_SHIFT;
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Handshake/status outputs registered from the next state so they track
    // state_r exactly without any input-to-output combinational path.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_ready_r <= 1'b1;
            busy_r      <= 1'b0;
            res_valid_r <= 1'b0;
        end else begin
            cmd_ready_r <= (state_s == ST_IDLE);
            busy_r      <= (state_s == ST_SHIFT);
            res_valid_r <= (state_s == ST_DONE);
        end
    end

    // Datapath: load on accept, step while shifting, hold otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_r <= {WIDTH{1'b0}};
            cnt_r   <= ZERO_AMT;
            dir_r   <= 1'b0;
            rot_r   <= 1'b0;
            fill_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        shift_r <= cmd_data;
                        cnt_r   <= load_cnt_s;
                        dir_r   <= cmd_lr_bar;
                        rot_r   <= cmd_rot;
                        fill_r  <= cmd_fill;
                    end
                end
                ST_SHIFT: begin
                    shift_r <= step_s;
                    cnt_r   <= cnt_r - ONE_AMT;
                end
                ST_DONE: begin
                    shift_r <= shift_r;
                end
                default: begin
                    shift_r <= shift_r;
                end
            endcase
        end
    end

    assign cmd_ready = cmd_ready_r;
    assign busy      = busy_r;
    assign res_valid = res_valid_r;
    assign res_data  = shift_r;

endmodule
